// File: rtl/word_frame_pkg.sv
// word_frame_pkg: definitions shared by the transmit framer and the
// receive-side word aligner.
//   SYNC_WORD_DEFAULT : training pattern the aligner searches for
//   state_e           : framer state encoding (IDLE / SYNC / DATA)
package word_frame_pkg;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hF731_8CEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/word_frame_fifo.sv
// word_frame_fifo: circular payload buffer for the framer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   wr_en_i    : write strobe (ignored while full, which latches ovf_o)
//   wr_data_i  : word to write
//   rd_en_i    : pop request (ignored while empty)
//   rd_data_o  : current head word (valid while !empty_o)
//   full_o     : registered count equals DEPTH
//   empty_o    : registered count is zero
//   ovf_o      : sticky, set by a write attempted while full
module word_frame_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             ovf_q;
  logic             wr_ok;
  logic             rd_ok;

  // Full is judged on the registered count, so a write that coincides with
  // a read while full is still dropped.
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_ok   = wr_en_i && !full_o;
  assign rd_ok   = rd_en_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q];
  assign ovf_o     = ovf_q;

  // Storage is not reset; clearing the count is enough to discard contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_en_i && full_o) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_frame_tx.sv
// word_frame_tx: transmit-side framer. Buffers payload words and, for each
// serializer request, emits one word: a sync training burst after PHY_INIT,
// then payload (or idle words when no payload is buffered).
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   PHY_INIT   : pulse that (re)starts a training burst
//   DIPUSH/DIN : payload write strobe and data
//   DIFULL     : payload buffer full
//   OVF        : sticky, a payload write was dropped
//   DOREQ      : serializer asks for one word this cycle
//   DOPUSH     : DOUT valid, one cycle after DOREQ
//   DOUT       : output word (holds while DOPUSH=0)
//   DODATA     : DOUT carries payload
//   TRAINING   : framer is sending the sync burst
module word_frame_tx
  import word_frame_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
  parameter int unsigned SYNC_CNT   = 16,
  parameter logic [31:0] IDLE_WORD  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PHY_INIT,
  input  logic        DIPUSH,
  input  logic [31:0] DIN,
  output logic        DIFULL,
  output logic        OVF,
  input  logic        DOREQ,
  output logic        DOPUSH,
  output logic [31:0] DOUT,
  output logic        DODATA,
  output logic        TRAINING
);

  // Count value held just before the request that sends the last sync word.
  localparam logic [7:0] LAST_SYNC = 8'(SYNC_CNT - 1);

  state_e      state_q;
  logic [7:0]  sync_cnt_q;
  logic        dopush_q;
  logic [31:0] dout_q;
  logic        dodata_q;

  logic        fifo_rd_en;
  logic [31:0] fifo_head;
  logic        fifo_empty;

  // PHY_INIT takes priority over a same-cycle request, so no pop then.
  assign fifo_rd_en = DOREQ && !PHY_INIT && (state_q == DATA);

  word_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .wr_en_i   (DIPUSH),
    .wr_data_i (DIN),
    .rd_en_i   (fifo_rd_en),
    .rd_data_o (fifo_head),
    .full_o    (DIFULL),
    .empty_o   (fifo_empty),
    .ovf_o     (OVF)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      sync_cnt_q <= '0;
      dopush_q   <= 1'b0;
      dout_q     <= '0;
      dodata_q   <= 1'b0;
    end else begin
      dopush_q <= DOREQ;
      dodata_q <= 1'b0;
      if (PHY_INIT) begin
        state_q <= SYNC;
        if (DOREQ) begin
          dout_q     <= SYNC_WORD;
          sync_cnt_q <= 8'd1;
        end else begin
          sync_cnt_q <= '0;
        end
      end else begin
        unique case (state_q)
          SYNC: begin
            if (DOREQ) begin
              dout_q     <= SYNC_WORD;
              sync_cnt_q <= sync_cnt_q + 8'd1;
              if (sync_cnt_q == LAST_SYNC) begin
                state_q <= DATA;
              end
            end
          end
          DATA: begin
            if (DOREQ) begin
              if (!fifo_empty) begin
                dout_q   <= fifo_head;
                dodata_q <= 1'b1;
              end else begin
                dout_q <= IDLE_WORD;
              end
            end
          end
          default: begin
            if (DOREQ) begin
              dout_q <= IDLE_WORD;
            end
          end
        endcase
      end
    end
  end

  assign DOPUSH   = dopush_q;
  assign DOUT     = dout_q;
  assign DODATA   = dodata_q;
  assign TRAINING = (state_q == SYNC);

endmodule

// File: tb/tb_word_frame_tx.sv
// Scoreboard bench for word_frame_tx: stimulus tasks update a queue-based
// reference model and push expected words; a negedge monitor pops and
// compares whenever DOPUSH is seen.
module tb_word_frame_tx;

  localparam logic [31:0] SYNC_W = 32'hF731_8CEF;
  localparam logic [31:0] IDLE_W = 32'h0000_0000;
  localparam int          SYNC_N = 16;
  localparam int          DEPTH  = 4;

  localparam int M_IDLE = 0;
  localparam int M_SYNC = 1;
  localparam int M_DATA = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PHY_INIT = 1'b0;
  logic        DIPUSH = 1'b0;
  logic [31:0] DIN = '0;
  logic        DOREQ = 1'b0;
  logic        DIFULL;
  logic        OVF;
  logic        DOPUSH;
  logic [31:0] DOUT;
  logic        DODATA;
  logic        TRAINING;

  word_frame_tx dut (
    .CLK      (CLK),
    .RST      (RST),
    .PHY_INIT (PHY_INIT),
    .DIPUSH   (DIPUSH),
    .DIN      (DIN),
    .DIFULL   (DIFULL),
    .OVF      (OVF),
    .DOREQ    (DOREQ),
    .DOPUSH   (DOPUSH),
    .DOUT     (DOUT),
    .DODATA   (DODATA),
    .TRAINING (TRAINING)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode, sync words sent in this burst, payload queue.
  int          m_mode = M_IDLE;
  int          m_sent = 0;
  logic [31:0] m_fifo[$];
  bit          m_ovf  = 1'b0;
  logic [31:0] m_last = '0;
  logic [32:0] exp_q[$];  // {dodata, word}

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_clear();
    m_mode = M_IDLE;
    m_sent = 0;
    m_fifo.delete();
    m_ovf  = 1'b0;
    m_last = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1; PHY_INIT = 1'b0; DIPUSH = 1'b0; DOREQ = 1'b0;
    @(posedge CLK); #1;
    model_clear();
    chk("rst_dopush", 32'(DOPUSH), 32'd0);
    chk("rst_dout", DOUT, 32'd0);
    chk("rst_dodata", 32'(DODATA), 32'd0);
    chk("rst_difull", 32'(DIFULL), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_training", 32'(TRAINING), 32'd0);
    RST = 1'b0;
  endtask

  // One clock cycle of stimulus; the model is advanced by the same rules
  // the framer must follow, then flag outputs are checked after the edge.
  task automatic cyc(input bit phy, input bit push, input logic [31:0] din, input bit req);
    bit          was_full;
    logic [32:0] e;
    PHY_INIT = phy; DIPUSH = push; DIN = din; DOREQ = req;
    was_full = (m_fifo.size() == DEPTH);
    e = '0;
    if (req) begin
      if (phy || m_mode == M_SYNC)
        e = {1'b0, SYNC_W};
      else if (m_mode == M_DATA && m_fifo.size() > 0)
        e = {1'b1, m_fifo.pop_front()};
      else
        e = {1'b0, IDLE_W};
    end
    if (phy) begin
      m_mode = M_SYNC;
      m_sent = req ? 1 : 0;
    end else if (req && m_mode == M_SYNC) begin
      m_sent++;
    end
    if (m_mode == M_SYNC && m_sent == SYNC_N) m_mode = M_DATA;
    if (push) begin
      if (was_full) m_ovf = 1'b1;
      else m_fifo.push_back(din);
    end
    if (req) begin
      exp_q.push_back(e);
      m_last = e[31:0];
    end
    @(posedge CLK); #1;
    PHY_INIT = 1'b0; DIPUSH = 1'b0; DOREQ = 1'b0;
    chk("training", 32'(TRAINING), 32'(m_mode == M_SYNC));
    chk("difull", 32'(DIFULL), 32'(m_fifo.size() == DEPTH));
    chk("ovf", 32'(OVF), 32'(m_ovf));
    if (!req) chk("dout_hold", DOUT, m_last);
  endtask

  // Monitor: every DOPUSH must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    logic [32:0] e;
    if (!RST) begin
      if (DOPUSH) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dopush actual=%h required=none t=%0t", DOUT, $time);
        end else begin
          e = exp_q.pop_front();
          chk("dout", DOUT, e[31:0]);
          chk("dodata", 32'(DODATA), 32'(e[32]));
        end
      end else begin
        chk("dodata_idle", 32'(DODATA), 32'd0);
      end
    end
  end

  initial begin
    // Initial reset state.
    @(posedge CLK); #1;
    do_reset();

    // Requests before any training return idle words.
    repeat (3) cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);

    // Training burst with empty FIFO, then idle words.
    cyc(1, 0, '0, 0);
    repeat (20) cyc(0, 0, '0, 1);

    // Payload written during training comes out after the burst.
    cyc(1, 0, '0, 0);
    cyc(0, 1, 32'h1111_1111, 0);
    cyc(0, 1, 32'h2222_2222, 0);
    repeat (18) cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);

    // Fill, overflow, drain.
    for (int k = 1; k <= 5; k++) cyc(0, 1, 32'hA000_0000 + 32'(k), 0);
    repeat (5) cyc(0, 0, '0, 1);

    // Burst restart after 10 sync words.
    do_reset();
    cyc(1, 1, 32'hBEEF_0001, 0);
    repeat (10) cyc(0, 0, '0, 1);
    cyc(1, 0, '0, 0);
    repeat (17) cyc(0, 0, '0, 1);

    // PHY_INIT together with a request counts as burst word 1.
    cyc(0, 1, 32'hBEEF_0002, 0);
    cyc(1, 0, '0, 1);
    repeat (16) cyc(0, 0, '0, 1);

    // Reset mid-stream with buffered payload.
    cyc(0, 1, 32'hC000_0001, 0);
    cyc(0, 1, 32'hC000_0002, 0);
    cyc(0, 1, 32'hC000_0003, 1);
    cyc(0, 0, '0, 0);
    do_reset();
    repeat (2) cyc(0, 0, '0, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 4, $urandom,
            $urandom_range(0, 9) < 6);
      end
    end

    repeat (2) cyc(0, 0, '0, 0);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
